fifo_frame_tx: RTL and testbench



---
 rtl/fifo_frame_tx_pkg.sv | 23 ++
 rtl/fifo_frame_tx.sv | 128 ++++++++++++
 tb/tb_fifo_frame_tx.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_frame_tx_pkg.sv
// Shared definitions for the FIFO-to-byte-stream frame transmitter.
package fifo_frame_tx_pkg;

  // Frame FSM states; 3-bit encoding.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SYNC = 3'd1,
    ST_POP  = 3'd2,
    ST_LOAD = 3'd3,
    ST_DATA = 3'd4,
    ST_CSUM = 3'd5
  } state_e;

  localparam int         DEFAULT_WIDTH     = 32;
  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;
  localparam int         BYTES_PER_WORD    = DEFAULT_WIDTH / 8;

  // Number of bytes carried by one FIFO word of the given width.
  function automatic int bytes_per_word(input int width);
    return width / 8;
  endfunction

endpackage

// File: rtl/fifo_frame_tx.sv
// Pops words from the word FIFO and sends them MSB-byte-first as frames:
// sync byte, FRAME_WORDS payload words, XOR checksum of the payload bytes.
module fifo_frame_tx
  import fifo_frame_tx_pkg::*;
#(
  parameter int         WIDTH       = DEFAULT_WIDTH,
  parameter int         FRAME_WORDS = 4,
  parameter logic [7:0] SYNC_BYTE   = DEFAULT_SYNC_BYTE
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             fifo_empty_i,
  output logic             fifo_rd_o,
  input  logic [WIDTH-1:0] fifo_data_i,
  output logic             tx_valid_o,
  output logic [7:0]       tx_data_o,
  input  logic             tx_ready_i,
  output logic             busy_o,
  output logic [15:0]      frame_cnt_o
);

  localparam int BPW = bytes_per_word(WIDTH);
  localparam int BCW = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int WCW = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
  localparam logic [BCW-1:0] LAST_BYTE = BCW'(BPW - 1);
  localparam logic [WCW-1:0] LAST_WORD = WCW'(FRAME_WORDS - 1);

  state_e           state_q;
  logic [WIDTH-1:0] shreg_q;
  logic [BCW-1:0]   byte_cnt_q;
  logic [WCW-1:0]   word_cnt_q;
  logic [7:0]       csum_q;
  logic             tx_valid_q;
  logic [7:0]       tx_data_q;
  logic [15:0]      frame_cnt_q;

  logic [WIDTH-1:0] shreg_rot;
  logic [7:0]       csum_next;

  // Rotate left by one byte so the next byte to send sits at the top; a
  // rotate rather than a shift keeps every register bit in use.
  assign shreg_rot = (shreg_q << 8) | (shreg_q >> (WIDTH - 8));
  assign csum_next = csum_q ^ tx_data_q;

  // Pop only while waiting for a word and only when one is available.
  // NOTE: plain continuous assigns cannot infer latches; keep combinational
  // decode here rather than in incomplete always blocks.
  assign fifo_rd_o   = (state_q == ST_POP) && !fifo_empty_i;
  assign busy_o      = (state_q != ST_IDLE);
  assign tx_valid_o  = tx_valid_q;
  assign tx_data_o   = tx_data_q;
  assign frame_cnt_o = frame_cnt_q;

  // Frame FSM with registered byte output, shift register and checksum.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q     <= ST_IDLE;
      // NOTE: the shift register is reset too, so a truncated frame leaves
      // no stale payload visible after reset.
      shreg_q     <= '0;
      byte_cnt_q  <= '0;
      word_cnt_q  <= '0;
      csum_q      <= '0;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= '0;
      frame_cnt_q <= '0;
    end else begin
      // In SYNC/DATA/CSUM tx_valid_q is always high, so tx_ready_i alone
      // marks the handshake there.
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty_i) begin
            state_q    <= ST_SYNC;
            tx_data_q  <= SYNC_BYTE;
            tx_valid_q <= 1'b1;
            csum_q     <= '0;
            word_cnt_q <= '0;
          end
        end
        ST_SYNC: begin
          if (tx_ready_i) begin
            state_q    <= ST_POP;
            tx_valid_q <= 1'b0;
          end
        end
        ST_POP: begin
          // Underrun mid-frame simply waits here; nothing is padded.
          if (!fifo_empty_i) state_q <= ST_LOAD;
        end
        ST_LOAD: begin
          shreg_q    <= fifo_data_i;
          byte_cnt_q <= '0;
          tx_data_q  <= fifo_data_i[WIDTH-1 -: 8];
          tx_valid_q <= 1'b1;
          state_q    <= ST_DATA;
        end
        ST_DATA: begin
          if (tx_ready_i) begin
            csum_q <= csum_next;
            if (byte_cnt_q != LAST_BYTE) begin
              shreg_q    <= shreg_rot;
              tx_data_q  <= shreg_rot[WIDTH-1 -: 8];
              byte_cnt_q <= byte_cnt_q + BCW'(1);
            end else if (word_cnt_q == LAST_WORD) begin
              state_q   <= ST_CSUM;
              tx_data_q <= csum_next;
            end else begin
              word_cnt_q <= word_cnt_q + WCW'(1);
              tx_valid_q <= 1'b0;
              state_q    <= ST_POP;
            end
          end
        end
        ST_CSUM: begin
          if (tx_ready_i) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
            tx_valid_q  <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_frame_tx.sv
// Self-checking bench for fifo_frame_tx (WIDTH=32, FRAME_WORDS=2) with a
// behavioural FIFO, a byte-stream monitor and a frame-level reference model.
module tb_fifo_frame_tx;

  localparam int         WIDTH = 32;
  localparam int         FW    = 2;
  localparam logic [7:0] SYNC  = 8'hA5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fifo_empty = 1'b1;
  logic        fifo_rd;
  logic [31:0] fifo_data = '0;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b0;
  logic        busy;
  logic [15:0] frame_cnt;

  always #5 clk = ~clk;

  fifo_frame_tx #(.WIDTH(WIDTH), .FRAME_WORDS(FW), .SYNC_BYTE(SYNC)) dut (
    .clk_i        (clk),
    .reset_ni     (rst_n),
    .fifo_empty_i (fifo_empty),
    .fifo_rd_o    (fifo_rd),
    .fifo_data_i  (fifo_data),
    .tx_valid_o   (tx_valid),
    .tx_data_o    (tx_data),
    .tx_ready_i   (tx_ready),
    .busy_o       (busy),
    .frame_cnt_o  (frame_cnt)
  );

  // Behavioural word FIFO: registered empty flag and read data.
  logic [31:0] mem_q[$];
  logic        push_en = 1'b0;
  logic [31:0] push_data = '0;
  logic        flush = 1'b0;
  int          rd_cnt = 0;

  always @(posedge clk) begin
    if (flush) mem_q.delete();
    if (push_en) mem_q.push_back(push_data);
    if (fifo_rd) begin
      rd_cnt++;
      if (mem_q.size() > 0) fifo_data <= mem_q.pop_front();
    end
    fifo_empty <= (mem_q.size() == 0);
  end

  // Stream monitor: records accepted bytes with their cycle stamp and
  // counts any change of a stalled byte.
  logic [7:0] got_q[$];
  int         got_t[$];
  int         cyc = 0;
  bit         prev_stall = 1'b0;
  logic [7:0] prev_data = '0;
  int         hold_viol = 0;

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && !(tx_valid && tx_data == prev_data)) hold_viol++;
      if (tx_valid && tx_ready) begin
        got_q.push_back(tx_data);
        got_t.push_back(cyc);
      end
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
    end
  end

  // Reference model state.
  logic [7:0]  exp_q[$];
  logic [31:0] pend_q[$];
  int          exp_words = 0;
  logic [15:0] exp_frames = '0;
  int          got_base = 0;

  int n_checks = 0;
  int n_errs = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Expected bytes of one frame, built directly from the frame definition.
  task automatic model_frame(input logic [31:0] w0, input logic [31:0] w1);
    logic [31:0] words[FW];
    logic [7:0]  b;
    logic [7:0]  cs;
    words[0] = w0;
    words[1] = w1;
    cs = '0;
    exp_q.push_back(SYNC);
    for (int w = 0; w < FW; w++) begin
      for (int k = WIDTH / 8 - 1; k >= 0; k--) begin
        b = words[w][8*k +: 8];
        exp_q.push_back(b);
        cs ^= b;
      end
    end
    exp_q.push_back(cs);
    exp_words += FW;
    exp_frames = exp_frames + 16'd1;
  endtask

  task automatic add_frame(input logic [31:0] w0, input logic [31:0] w1);
    model_frame(w0, w1);
    pend_q.push_back(w0);
    pend_q.push_back(w1);
  endtask

  // Feed pending words, run until the frame is out, compare everything.
  task automatic drain(input string name, input bit rnd);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    while (!done && n < 4000) begin
      @(negedge clk);
      n++;
      push_en = 1'b0;
      if (pend_q.size() > 0 && (!rnd || $urandom_range(0, 1) == 1)) begin
        push_en   = 1'b1;
        push_data = pend_q.pop_front();
      end
      if (rnd) tx_ready = ($urandom_range(0, 3) != 0);
      done = (pend_q.size() == 0) && !push_en && fifo_empty && !busy &&
             (got_q.size() - got_base >= exp_q.size());
    end
    push_en  = 1'b0;
    tx_ready = 1'b1;
    check({name, " timeout"}, 32'(done), 32'd1);
    check({name, " len"}, 32'(got_q.size() - got_base), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && got_base + i < got_q.size(); i++)
      check({name, " byte"}, 32'(got_q[got_base+i]), 32'(exp_q[i]));
    check({name, " rd_cnt"}, 32'(rd_cnt), 32'(exp_words));
    check({name, " frame_cnt"}, 32'(frame_cnt), 32'(exp_frames));
    check({name, " hold"}, 32'(hold_viol), 32'd0);
    got_base = got_q.size();
    exp_q.delete();
  endtask

  typedef struct {
    logic [31:0] w0;
    logic [31:0] w1;
    logic [7:0]  csum;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int base;
    bit found;

    vecs[0] = '{32'h11223344, 32'hA0B0C0D0, 8'h44};
    vecs[1] = '{32'h01020304, 32'h05060708, 8'h08};
    vecs[2] = '{32'hFFFFFFFF, 32'h00000000, 8'h00};
    vecs[3] = '{32'h12345678, 32'h9ABCDEF0, 8'h00};
    vecs[4] = '{32'hDEADBEEF, 32'h00000001, 8'h23};

    // Reset: outputs low during and right after reset.
    #1;
    check("reset outputs", {5'd0, tx_valid, tx_data, fifo_rd, busy, frame_cnt}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post-reset outputs", {5'd0, tx_valid, tx_data, fifo_rd, busy, frame_cnt}, 32'd0);

    // Empty FIFO: stays idle.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle empty", {29'd0, tx_valid, fifo_rd, busy}, 32'd0);
    end

    // Basic frame with first-byte latency and inter-word gap.
    tx_ready = 1'b1;
    model_frame(32'h11223344, 32'hA0B0C0D0);
    base = got_base;
    push_en = 1'b1;
    push_data = 32'h11223344;
    @(negedge clk);
    check("empty fell", 32'(fifo_empty), 32'd0);
    check("no byte yet", 32'(tx_valid), 32'd0);
    push_data = 32'hA0B0C0D0;
    @(negedge clk);
    push_en = 1'b0;
    check("first byte valid", 32'(tx_valid), 32'd1);
    check("first byte sync", 32'(tx_data), 32'(SYNC));
    drain("basic", 1'b0);
    check("sync->word gap", 32'(got_t[base+1] - got_t[base]), 32'd3);
    check("word->word gap", 32'(got_t[base+5] - got_t[base+4]), 32'd3);
    check("basic busy low", 32'(busy), 32'd0);

    // Table of frames with hand-computed checksums.
    for (int v = 0; v < 5; v++) begin
      add_frame(vecs[v].w0, vecs[v].w1);
      drain("table", 1'b0);
      check("table csum", 32'(got_q[got_base-1]), 32'(vecs[v].csum));
    end

    // Backpressure on byte 0x33 for three cycles.
    model_frame(32'h11223344, 32'hA0B0C0D0);
    @(negedge clk);
    push_en = 1'b1;
    push_data = 32'h11223344;
    @(negedge clk);
    push_data = 32'hA0B0C0D0;
    @(negedge clk);
    push_en = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (tx_valid && tx_data == 8'h33) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("bp found 33", 32'(found), 32'd1);
    tx_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("bp hold", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, 8'h33});
    end
    tx_ready = 1'b1;
    drain("backpressure", 1'b0);

    // Underrun: second word arrives late.
    model_frame(32'h11223344, 32'hA0B0C0D0);
    @(negedge clk);
    push_en = 1'b1;
    push_data = 32'h11223344;
    @(negedge clk);
    push_en = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (got_q.size() - got_base == 5) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("underrun 5 bytes", 32'(found), 32'd1);
    repeat (10) begin
      @(negedge clk);
      check("underrun stall", {29'd0, fifo_rd, tx_valid, busy}, 32'd1);
    end
    pend_q.push_back(32'hA0B0C0D0);
    drain("underrun", 1'b0);

    // Randomised frames, random FIFO fill and random ready.
    for (int f = 0; f < 25; f++) begin
      add_frame($urandom, $urandom);
      drain("random", 1'b1);
    end

    // Reset mid-frame, after byte 0x22.
    @(negedge clk);
    push_en = 1'b1;
    push_data = 32'h11223344;
    @(negedge clk);
    push_data = 32'hA0B0C0D0;
    @(negedge clk);
    push_en = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (got_q.size() - got_base == 3) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("pre-reset bytes", 32'(found), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async reset outputs", {5'd0, tx_valid, tx_data, fifo_rd, busy, frame_cnt}, 32'd0);
    exp_words += 1;
    exp_frames = '0;
    got_base = got_q.size();
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("after release", {5'd0, tx_valid, tx_data, fifo_rd, busy, frame_cnt}, 32'd0);
    add_frame(32'h01020304, 32'h05060708);
    drain("post-reset", 1'b0);
    check("post-reset csum", 32'(got_q[got_base-1]), 32'h08);

    // Counter wrap: preload 0xFFFF, one more frame wraps to 0.
    @(negedge clk);
    force dut.frame_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.frame_cnt_q;
    @(negedge clk);
    check("cnt preload", 32'(frame_cnt), 32'h0000FFFF);
    exp_frames = 16'hFFFF;
    add_frame(32'h11223344, 32'hA0B0C0D0);
    drain("wrap", 1'b0);
    check("cnt wrapped", 32'(frame_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
